// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: digit data / load strobe toward the scanner and
// segment / select / frame_start outputs back from it.
// The master side supplies digits; the scanner block uses the slave modport.
interface seg_scan_driver_if #(
    parameter int NUM_DIG = 8
);
    logic [4*NUM_DIG-1:0] dig_data;
    logic [NUM_DIG-1:0]   dp_mask;
    logic                 load;
    logic [7:0]           seg;
    logic [NUM_DIG-1:0]   sel;
    logic                 frame_start;

    modport master (
        output dig_data,
        output dp_mask,
        output load,
        input  seg,
        input  sel,
        input  frame_start
    );

    modport slave (
        input  dig_data,
        input  dp_mask,
        input  load,
        output seg,
        output sel,
        output frame_start
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode seven-segment scanner.
// Each digit slot starts with BLANK_CYC cycles of all selects off to avoid
// ghosting. New digit data is staged in a pending buffer and only copied
// into the displayed shadow at a frame boundary, so a frame never mixes
// two loads. Segments and selects are active-low and registered.
// Optional leading-zero blanking is built when the macro SEG_LZB_EN is
// defined; without it zeros always render as "0".
module seg_scan_driver #(
    parameter int NUM_DIG   = 8,
    parameter int SCAN_DIV  = 12000,
    parameter int BLANK_CYC = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIG - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_e;

    localparam slot_state_e ST_RESET = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

    // Scan position
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    slot_state_e      state_q, state_d;
    logic             slot_end;
    logic             frame_end;

    // Frame buffering
    logic [NUM_DIG-1:0][3:0] pend_data_q, pend_data_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [NUM_DIG-1:0][3:0] shadow_q, shadow_d;
    logic [NUM_DIG-1:0][3:0] dig_in;

    // Rendering
    logic [NUM_DIG-1:0] lzb_mask;
    logic [3:0]         cur_nib;
    logic               cur_blank;
    logic [7:0]         seg_q, seg_d;
    logic [NUM_DIG-1:0] sel_q, sel_d;
    logic               frame_start_q, frame_start_d;

    // Active-low 7-segment pattern (g..a) for one nibble; dp handled outside.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h3F;
            4'hF:    pat = 7'h7F;
            default: pat = 7'h06;
        endcase
        return pat;
    endfunction

    assign dig_in    = bus.dig_data;
    assign slot_end  = (div_cnt_q == DIV_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Slot divider, digit index and frame_start pulse generation.
    always_comb begin
        div_cnt_d     = div_cnt_q + 1'b1;
        idx_d         = idx_q;
        frame_start_d = frame_end;
        if (slot_end) begin
            div_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Slot phase FSM: BLANK for the first BLANK_CYC cycles, then SHOW.
    always_comb begin
        state_d = ST_SHOW;
        if (div_cnt_d < BLANK_END) begin
            state_d = ST_BLANK;
        end
    end

    // Pending/shadow buffering: last load wins, shadow only moves at frame end.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_vld_d  = pend_vld_q;
        shadow_d    = shadow_q;
        if (bus.load) begin
            pend_data_d = dig_in;
            pend_vld_d  = 1'b1;
        end
        if (frame_end) begin
            if (bus.load) begin
                shadow_d   = dig_in;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                shadow_d   = pend_data_q;
                pend_vld_d = 1'b0;
            end
        end
    end

`ifdef SEG_LZB_EN
    // Leading zeros (left of the first non-zero, non-blank digit) go dark.
    always_comb begin
        logic lead;
        lead     = 1'b1;
        lzb_mask = '0;
        for (int k = NUM_DIG - 1; k >= 1; k--) begin
            if (lead && (shadow_q[k] == 4'h0)) begin
                lzb_mask[k] = 1'b1;
            end
            if ((shadow_q[k] != 4'h0) && (shadow_q[k] != 4'hF)) begin
                lead = 1'b0;
            end
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // Segment pattern for the current digit and the one-hot-low select.
    always_comb begin
        cur_nib   = shadow_q[idx_q];
        cur_blank = (cur_nib == 4'hF) || lzb_mask[idx_q];
        seg_d     = 8'hFF;
        if (!cur_blank) begin
            seg_d = {~bus.dp_mask[idx_q], seg_decode(cur_nib)};
        end
        sel_d = '1;
        for (int k = 0; k < NUM_DIG; k++) begin
            if ((state_q == ST_SHOW) && (idx_q == IDX_W'(k))) begin
                sel_d[k] = 1'b0;
            end
        end
    end

    // Control, shadow and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            state_q       <= ST_RESET;
            pend_vld_q    <= 1'b0;
            shadow_q      <= '1;
            seg_q         <= 8'hFF;
            sel_q         <= '1;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            pend_vld_q    <= pend_vld_d;
            shadow_q      <= shadow_d;
            seg_q         <= seg_d;
            sel_q         <= sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Pending data is qualified by pend_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_data_q <= pend_data_d;
    end

    assign bus.seg         = seg_q;
    assign bus.sel         = sel_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (NUM_DIG=4, SCAN_DIV=8, BLANK_CYC=2).
// Expected values are hand-derived; define SEG_LZB_EN for the blanking build.
module tb_seg_scan_driver;

    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

`ifdef SEG_LZB_EN
    localparam logic [7:0] Z_LEAD    = 8'hFF;
    localparam logic [7:0] Z_LEAD_DP = 8'hFF;
`else
    localparam logic [7:0] Z_LEAD    = 8'hC0;
    localparam logic [7:0] Z_LEAD_DP = 8'h40;
`endif

    seg_scan_driver_if #(.NUM_DIG(ND)) bus ();

    seg_scan_driver #(
        .NUM_DIG  (ND),
        .SCAN_DIV (8),
        .BLANK_CYC(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until frame_start, checking dark segments; expects 32 cycles.
    task automatic count_fs(input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            step();
            n++;
            chk($sformatf("%s dark seg n%0d", tag, n), bus.seg, 8'hFF);
            if (bus.frame_start === 1'b1) seen = 1'b1;
        end
        total++;
        assert (seen && n == 32) else begin
            bad++;
            $error("FAIL %s frame_start delay: got %0d want 32", tag, n);
        end
    endtask

    // Checks one full frame starting at an observed frame_start, with up to
    // two optional load pulses driven after the checks of step ls1 / ls2.
    task automatic run_frame(input string tag,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input int ls1, input logic [15:0] ld1,
                             input int ls2, input logic [15:0] ld2);
        logic [7:0] e [4];
        logic [3:0] exp_sel;
        int dig;
        int ph;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int s = 1; s <= 32; s++) begin
            step();
            dig     = (s - 1) / 8;
            ph      = (s - 1) % 8;
            exp_sel = (ph >= 2) ? ~(4'b0001 << dig) : 4'hF;
            chk($sformatf("%s seg s%0d", tag, s), bus.seg, e[dig]);
            chk($sformatf("%s sel s%0d", tag, s), {4'h0, bus.sel}, {4'h0, exp_sel});
            chk($sformatf("%s frame_start s%0d", tag, s), {7'd0, bus.frame_start},
                (s == 32) ? 8'd1 : 8'd0);
            if (s == ls1) begin
                bus.dig_data = ld1;
                bus.load     = 1'b1;
            end else if (s == ls2) begin
                bus.dig_data = ld2;
                bus.load     = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.dig_data = 16'h0000;
        bus.dp_mask  = 4'b0000;
        step(); step(); step();
        chk("reset seg", bus.seg, 8'hFF);
        chk("reset sel", {4'h0, bus.sel}, 8'h0F);
        chk("reset frame_start", {7'd0, bus.frame_start}, 8'd0);
        rst_n = 1'b1;
        count_fs("idle");

        // Idle frame stays dark; 1234 loaded mid-frame.
        run_frame("idle_frame", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5, 16'h1234, -1, 16'h0000);
        // 1234 shown; two loads, the second must win.
        run_frame("f1234", 8'h99, 8'hB0, 8'hA4, 8'hF9, 4, 16'h1111, 20, 16'hA905);
        // A905 shown; load on the boundary cycle.
        run_frame("fA905", 8'h92, 8'hC0, 8'h90, 8'hBF, 31, 16'h5678, -1, 16'h0000);
        run_frame("f5678", 8'h80, 8'hF8, 8'h82, 8'h92, 10, 16'h00A7, -1, 16'h0000);
        bus.dp_mask = 4'b0010;
        run_frame("f00A7", 8'hF8, 8'h3F, Z_LEAD, Z_LEAD, 12, 16'h0000, -1, 16'h0000);
        run_frame("f0000", 8'hC0, Z_LEAD_DP, Z_LEAD, Z_LEAD, 7, 16'hFCB0, -1, 16'h0000);
        bus.dp_mask = 4'b1001;
        run_frame("fFCB0", 8'h40, 8'h86, 8'h86, 8'hFF, -1, 16'h0000, -1, 16'h0000);

        // Reset during SHOW of digit 0 with a load still pending.
        bus.dig_data = 16'h1234;
        bus.load     = 1'b1;
        step();
        bus.load = 1'b0;
        step(); step(); step();
        chk("pre-reset sel", {4'h0, bus.sel}, 8'h0E);
        chk("pre-reset seg", bus.seg, 8'h40);
        rst_n = 1'b0;
        step();
        chk("midrst seg", bus.seg, 8'hFF);
        chk("midrst sel", {4'h0, bus.sel}, 8'h0F);
        chk("midrst frame_start", {7'd0, bus.frame_start}, 8'd0);
        rst_n = 1'b1;
        count_fs("after_rst");
        run_frame("post_rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 16'h0000, -1, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
